// File: rtl/project.sv
// Multicycle control unit for a 4-bit-opcode MIPS-style CPU with a hardware stack.
// This is a Moore machine. Every datapath control is a function of the current state only.
// The controls are registered alongside the state: each edge loads the decode of the state
// that cs is about to take, so each output still matches cs exactly.
module project (
  output logic [4:0] cs,
  output logic [4:0] ns,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       AluSrcC,
  output logic [1:0] AluOp,
  output logic       IorD,
  output logic       IRWrite,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       SPWrite,
  output logic       PCMUX,
  output logic       PCWriteCond,
  output logic       RegSrc,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       RegDst,
  input  logic [3:0] opcode,
  input  logic [3:0] func,
  input  logic       clk,
  input  logic       rst
);

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,  S_DECODE  = 5'd1,  S_MEMADR  = 5'd2,  S_MEMRD   = 5'd3,
    S_LWWB    = 5'd4,  S_MEMWR   = 5'd5,  S_REXE    = 5'd6,  S_RWB     = 5'd7,
    S_BEQ     = 5'd8,  S_JUMP    = 5'd9,  S_ADDIEXE = 5'd10, S_ADDIWB  = 5'd11,
    S_PUSHSP  = 5'd12, S_PUSHWR  = 5'd13, S_POPADR  = 5'd14, S_POPRD   = 5'd15,
    S_POPWB   = 5'd16, S_RETADR  = 5'd17, S_RETRD   = 5'd18, S_JAL     = 5'd19,
    S_JR      = 5'd20
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_src_c;
    logic [1:0] alu_op;
    logic       iord;
    logic       ir_write;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       sp_write;
    logic       pc_mux;
    logic       pc_write_cond;
    logic       reg_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
  } ctrl_t;

  state_t r_cs;
  state_t w_ns;
  ctrl_t  r_ctrl;

  // Control decode for one state. Any state not listed drives every control low.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  begin c.alu_src_b = 2'b11; end
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_LWWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_REXE:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RWB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BEQ:     begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_src = 2'b01; end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      S_ADDIEXE: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:  begin c.reg_write = 1'b1; end
      S_PUSHSP:  begin c.alu_src_a = 1'b1; c.alu_src_c = 1'b1; c.alu_src_b = 2'b01;
                       c.alu_op = 2'b01; c.sp_write = 1'b1; end
      S_PUSHWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_POPADR:  begin c.alu_src_a = 1'b1; c.alu_src_c = 1'b1; c.alu_op = 2'b11; end
      S_POPRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; c.alu_src_a = 1'b1; c.alu_src_c = 1'b1;
                       c.alu_src_b = 2'b01; c.sp_write = 1'b1; end
      S_POPWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_RETADR:  begin c.alu_src_a = 1'b1; c.alu_src_c = 1'b1; c.alu_op = 2'b11; end
      S_RETRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; c.pc_write = 1'b1; c.pc_mux = 1'b1;
                       c.alu_src_a = 1'b1; c.alu_src_c = 1'b1; c.alu_src_b = 2'b01; c.sp_write = 1'b1; end
      S_JAL:     begin c.reg_write = 1'b1; c.reg_src = 1'b1; c.pc_write = 1'b1; c.pc_src = 2'b10; end
      S_JR:      begin c.alu_src_a = 1'b1; c.alu_op = 2'b11; c.pc_write = 1'b1; end
      default:   begin c = '0; end
    endcase
    return c;
  endfunction

  // Next-state logic. opcode and func are consulted only in DECODE and MEMADR.
  always_comb begin
    w_ns = S_FETCH;
    case (r_cs)
      S_FETCH:   w_ns = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0000: w_ns = (func == 4'b1000) ? S_JR : S_REXE;
          4'b0001: w_ns = S_ADDIEXE;
          4'b0010: w_ns = S_MEMADR;
          4'b0011: w_ns = S_MEMADR;
          4'b0100: w_ns = S_BEQ;
          4'b0101: w_ns = S_JUMP;
          4'b0110: w_ns = S_PUSHSP;
          4'b0111: w_ns = S_POPADR;
          4'b1000: w_ns = S_RETADR;
          4'b1001: w_ns = S_JAL;
          default: w_ns = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == 4'b0010) begin
          w_ns = S_MEMRD;
        end else if (opcode == 4'b0011) begin
          w_ns = S_MEMWR;
        end else begin
          w_ns = S_FETCH;
        end
      end
      S_MEMRD:   w_ns = S_LWWB;
      S_REXE:    w_ns = S_RWB;
      S_ADDIEXE: w_ns = S_ADDIWB;
      S_PUSHSP:  w_ns = S_PUSHWR;
      S_POPADR:  w_ns = S_POPRD;
      S_POPRD:   w_ns = S_POPWB;
      S_RETADR:  w_ns = S_RETRD;
      default:   w_ns = S_FETCH;
    endcase
  end

  // State register and its matching registered controls. Reset forces FETCH at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cs   <= S_FETCH;
      r_ctrl <= decode_ctrl(S_FETCH);
    end else begin
      r_cs   <= w_ns;
      r_ctrl <= decode_ctrl(w_ns);
    end
  end

  assign cs          = r_cs;
  assign ns          = w_ns;
  assign MemRead     = r_ctrl.mem_read;
  assign MemWrite    = r_ctrl.mem_write;
  assign AluSrcA     = r_ctrl.alu_src_a;
  assign AluSrcB     = r_ctrl.alu_src_b;
  assign AluSrcC     = r_ctrl.alu_src_c;
  assign AluOp       = r_ctrl.alu_op;
  assign IorD        = r_ctrl.iord;
  assign IRWrite     = r_ctrl.ir_write;
  assign PCSrc       = r_ctrl.pc_src;
  assign PCWrite     = r_ctrl.pc_write;
  assign SPWrite     = r_ctrl.sp_write;
  assign PCMUX       = r_ctrl.pc_mux;
  assign PCWriteCond = r_ctrl.pc_write_cond;
  assign RegSrc      = r_ctrl.reg_src;
  assign RegWrite    = r_ctrl.reg_write;
  assign MemToReg    = r_ctrl.mem_to_reg;
  assign RegDst      = r_ctrl.reg_dst;

endmodule

// File: tb/tb_project.sv
// Self-checking bench for the multicycle control unit.
// The reference model is a table of state walks per instruction plus a table of control outputs per state.
// While an instruction runs outside DECODE and MEMADR, the bench drives random opcode and func values.
module tb_project;

  logic [4:0] cs, ns;
  logic       MemRead, MemWrite, AluSrcA, AluSrcC, IorD, IRWrite, PCWrite, SPWrite, PCMUX;
  logic       PCWriteCond, RegSrc, RegWrite, MemToReg, RegDst;
  logic [1:0] AluSrcB, AluOp, PCSrc;
  logic [3:0] opcode, func;
  logic       clk, rst;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_path[$];

  project dut (
    .cs(cs), .ns(ns), .MemRead(MemRead), .MemWrite(MemWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .AluSrcC(AluSrcC), .AluOp(AluOp), .IorD(IorD), .IRWrite(IRWrite),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .SPWrite(SPWrite), .PCMUX(PCMUX),
    .PCWriteCond(PCWriteCond), .RegSrc(RegSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .RegDst(RegDst), .opcode(opcode), .func(func), .clk(clk), .rst(rst)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the observed control outputs in a fixed order.
  function automatic logic [20:0] obs_ctrl();
    return {MemRead, MemWrite, AluSrcA, AluSrcB, AluSrcC, AluOp, IorD, IRWrite, PCSrc,
            PCWrite, SPWrite, PCMUX, PCWriteCond, RegSrc, RegWrite, MemToReg, RegDst};
  endfunction

  // Expected controls for each state. Any control not named for a state is zero.
  function automatic logic [20:0] exp_ctrl(input int s);
    logic mr, mw, asa, asc, iord, irw, pcw, spw, pcm, pcwc, rs, rw, m2r, rd;
    logic [1:0] asb, aop, pcs;
    {mr, mw, asa, asc, iord, irw, pcw, spw, pcm, pcwc, rs, rw, m2r, rd} = 14'd0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      0:  begin mr = 1'b1; irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iord = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: rw = 1'b1;
      12: begin asa = 1'b1; asc = 1'b1; asb = 2'b01; aop = 2'b01; spw = 1'b1; end
      13: begin mw = 1'b1; iord = 1'b1; end
      14: begin asa = 1'b1; asc = 1'b1; aop = 2'b11; end
      15: begin mr = 1'b1; iord = 1'b1; asa = 1'b1; asc = 1'b1; asb = 2'b01; spw = 1'b1; end
      16: begin rw = 1'b1; m2r = 1'b1; end
      17: begin asa = 1'b1; asc = 1'b1; aop = 2'b11; end
      18: begin mr = 1'b1; iord = 1'b1; pcw = 1'b1; pcm = 1'b1; asa = 1'b1; asc = 1'b1;
                asb = 2'b01; spw = 1'b1; end
      19: begin rw = 1'b1; rs = 1'b1; pcw = 1'b1; pcs = 2'b10; end
      20: begin asa = 1'b1; aop = 2'b11; pcw = 1'b1; end
      default: ;
    endcase
    return {mr, mw, asa, asb, asc, aop, iord, irw, pcs, pcw, spw, pcm, pcwc, rs, rw, m2r, rd};
  endfunction

  // Fill exp_path with the sequence of states one instruction walks through, starting at FETCH.
  task automatic build_path(input logic [3:0] op, input logic [3:0] fn);
    exp_path = {0, 1};
    case (op)
      4'b0000: if (fn == 4'b1000) exp_path.push_back(20);
               else begin exp_path.push_back(6); exp_path.push_back(7); end
      4'b0001: begin exp_path.push_back(10); exp_path.push_back(11); end
      4'b0010: begin exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4); end
      4'b0011: begin exp_path.push_back(2); exp_path.push_back(5); end
      4'b0100: exp_path.push_back(8);
      4'b0101: exp_path.push_back(9);
      4'b0110: begin exp_path.push_back(12); exp_path.push_back(13); end
      4'b0111: begin exp_path.push_back(14); exp_path.push_back(15); exp_path.push_back(16); end
      4'b1000: begin exp_path.push_back(17); exp_path.push_back(18); end
      4'b1001: exp_path.push_back(19);
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Run one instruction. Entry is #1 after the edge that loaded FETCH; exit is #1 after the edge back to FETCH.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] fn);
    int nxt;
    build_path(op, fn);
    for (int k = 0; k < exp_path.size(); k++) begin
      check("cs", {27'd0, cs}, exp_path[k]);
      if (exp_path[k] == 1 || exp_path[k] == 2) begin
        opcode = op; func = fn;
      end else begin
        opcode = 4'($urandom); func = 4'($urandom);
      end
      #1;
      nxt = (k + 1 < exp_path.size()) ? exp_path[k + 1] : 0;
      check("ns", {27'd0, ns}, nxt);
      check("ctrl", {11'd0, obs_ctrl()}, {11'd0, exp_ctrl(exp_path[k])});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [3:0] op, fn;
    rst = 1'b0; opcode = 4'b0100; func = 4'b0000;
    @(posedge clk); #1;
    check("rst_cs", {27'd0, cs}, 0);
    check("rst_ns", {27'd0, ns}, 1);
    check("rst_ctrl", {11'd0, obs_ctrl()}, {11'd0, exp_ctrl(0)});
    rst = 1'b1;

    // Cover every opcode, and both R-type function flavours.
    for (int i = 0; i < 16; i++) run_instr(4'(i), 4'b0001);
    run_instr(4'b0000, 4'b1000);
    run_instr(4'b0100, 4'b0000);
    run_instr(4'b0100, 4'b0000);

    // Reset mid-POP while cs is 15.
    build_path(4'b0111, 4'b0000);
    opcode = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      check("pop_cs", {27'd0, cs}, exp_path[k]);
      if (k == 3) rst = 1'b0;
      @(posedge clk); #1;
    end
    check("mid_rst_cs", {27'd0, cs}, 0);
    check("mid_rst_ns", {27'd0, ns}, 1);
    check("mid_rst_sp", {31'd0, SPWrite}, 0);
    check("mid_rst_ctrl", {11'd0, obs_ctrl()}, {11'd0, exp_ctrl(0)});
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cs", {27'd0, cs}, 1);
    check("post_rst_sp", {31'd0, SPWrite}, 0);
    // cs is at DECODE now. Finish a NOP so the next instruction starts from FETCH.
    opcode = 4'b1111;
    @(posedge clk); #1;

    // Random instructions.
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 15));
      fn = ($urandom_range(0, 1) == 0) ? 4'b1000 : 4'($urandom);
      run_instr(op, fn);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
